// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer control/address bundle: redirect/hazard requests in,
// registered fetch address and status out.
interface pc_fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              stall_i;
    logic              br_taken_i;
    logic [ADDR_W-1:0] br_target_i;
    logic              jmp_i;
    logic [ADDR_W-1:0] jmp_target_i;
    logic              halt_i;
    logic              resume_i;
    logic [ADDR_W-1:0] pc_o;
    logic              fetch_valid_o;
    logic              flush_o;
    logic              wrap_o;
    logic [1:0]        state_o;
    logic [7:0]        redirect_cnt_o;

    modport master (
        output stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
               halt_i, resume_i,
        input  pc_o, fetch_valid_o, flush_o, wrap_o, state_o, redirect_cnt_o
    );

    modport slave (
        input  stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
               halt_i, resume_i,
        output pc_o, fetch_valid_o, flush_o, wrap_o, state_o, redirect_cnt_o
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: picks sequential, branch, jump, stall or halt
// next-PC each cycle, flushes IF/ID on redirects and counts them.
module pc_fetch_sequencer #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       FLUSH_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_fetch_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic [7:0]        redirect_cnt_q, redirect_cnt_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              flush_q, flush_d;
    logic              wrap_q, wrap_d;

    logic              redirect_req;
    logic              do_redirect;
    logic              do_inc;
    logic [ADDR_W-1:0] redirect_tgt;

    assign redirect_req = bus.jmp_i | bus.br_taken_i;
    assign redirect_tgt = bus.jmp_i ? bus.jmp_target_i : bus.br_target_i;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        flush_cnt_d    = flush_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        do_redirect    = 1'b0;
        do_inc         = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (redirect_req) begin
                    do_redirect = 1'b1;
                end else if (bus.halt_i) begin
                    state_d = ST_HALT;
                end else if (bus.stall_i) begin
                    state_d = ST_STALL;
                end else begin
                    // First RUN cycle after reset fetches RESET_VEC itself
                    do_inc = fetch_valid_q;
                end
            end
            ST_STALL: begin
                if (redirect_req) begin
                    do_redirect = 1'b1;
                end else if (bus.halt_i) begin
                    state_d = ST_HALT;
                end else if (!bus.stall_i) begin
                    state_d = ST_RUN;
                    do_inc  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (redirect_req) begin
                    do_redirect = 1'b1;
                end else if (flush_cnt_q <= 2'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            ST_HALT: begin
                if (bus.resume_i) begin
                    state_d = ST_RUN;
                    do_inc  = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (do_redirect) begin
            state_d     = ST_FLUSH;
            pc_d        = redirect_tgt;
            flush_cnt_d = FLUSH_LD;
            if (redirect_cnt_q != 8'hFF) begin
                redirect_cnt_d = redirect_cnt_q + 8'd1;
            end
        end

        if (do_inc) begin
            pc_d = pc_q + 1'b1;
        end

        // Only the sequential path can wrap; a redirect to 0 never does
        wrap_d        = do_inc && (pc_q == '1);
        fetch_valid_d = (state_d == ST_RUN);
        flush_d       = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_VEC;
            flush_cnt_q    <= '0;
            redirect_cnt_q <= '0;
            fetch_valid_q  <= 1'b0;
            flush_q        <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            flush_cnt_q    <= flush_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
            fetch_valid_q  <= fetch_valid_d;
            flush_q        <= flush_d;
            wrap_q         <= wrap_d;
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.fetch_valid_o  = fetch_valid_q;
    assign bus.flush_o        = flush_q;
    assign bus.wrap_o         = wrap_q;
    assign bus.state_o        = state_q;
    assign bus.redirect_cnt_o = redirect_cnt_q;
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch-stage controller that owns and sequences the program counter for the pipeline. Each cycle it selects the next fetch address from sequential increment, branch target, jump target, stall hold or halt hold. It raises a flush to the IF/ID register on every redirect and keeps a saturating count of redirects for debug. It sits between the hazard/branch-resolution logic and the instruction memory address port.

Parameters:
ADDR_W, 8, width of the program counter and all address ports
RESET_VEC, 0, value loaded into the PC on reset
FLUSH_CYC, 1, number of cycles flush_o stays high after a redirect (1..3)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  hazard unit requests PC hold
br_taken_i  input  1  resolved branch is taken this cycle
br_target_i  input  ADDR_W  branch target address
jmp_i  input  1  unconditional jump this cycle
jmp_target_i  input  ADDR_W  jump target address
halt_i  input  1  halt request (halt instruction decoded)
resume_i  input  1  leave HALT
pc_o  output  ADDR_W  current fetch address (registered)
fetch_valid_o  output  1  pc_o is a valid fetch this cycle
flush_o  output  1  invalidate IF/ID contents
wrap_o  output  1  one-cycle pulse when PC wrapped max->0
state_o  output  2  RUN=0, STALL=1, FLUSH=2, HALT=3
redirect_cnt_o  output  8  saturating count of taken redirects

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-FLUSH or HALT): pc_o=RESET_VEC, state RUN, fetch_valid_o=0, flush_o=0, wrap_o=0, redirect_cnt_o=0, flush counter=0. The first valid fetch is the cycle after rst drops; fetch_valid_o=1 from that cycle.
- Event priority per cycle, evaluated in order (the first match wins):
  - redirect: jmp_i, or else br_taken_i.
  - halt_i.
  - stall_i.
  - sequential increment.
- Simultaneous jmp_i and br_taken_i: the jump target is used; the branch is dropped.
- RUN:
  - redirect -> pc_o<=target, state FLUSH, flush counter<=FLUSH_CYC, redirect_cnt_o+1 (saturates at 255).
  - halt_i -> state HALT, pc_o held.
  - stall_i -> state STALL, pc_o held.
  - otherwise pc_o<=pc_o+1.
- STALL: pc_o held, fetch_valid_o=0.
  - redirect -> FLUSH as in RUN.
  - halt_i -> HALT.
  - stall_i low -> RUN; the increment resumes the following cycle.
- FLUSH: flush_o=1, fetch_valid_o=0, pc_o held at the target. The counter decrements each cycle; at 0 the state goes to RUN and the first fetch of the target is valid.
  - stall_i and halt_i are ignored in FLUSH.
  - A new redirect in FLUSH loads the new target, reloads the counter to FLUSH_CYC and increments redirect_cnt_o.
- HALT: pc_o held, fetch_valid_o=0, flush_o=0. Redirects and stall_i are ignored. resume_i -> RUN, and pc_o increments from the held value the next cycle.
- Arithmetic: increment is modulo 2^ADDR_W. When pc_o goes from all-ones to 0, wrap_o=1 for exactly that cycle. A redirect to 0 does not set wrap_o.
- All outputs are registered.
- Latency: a redirect input sampled at edge N gives pc_o=target after edge N, flush_o high for cycles N+1..N+FLUSH_CYC, and the first valid fetch at N+FLUSH_CYC+1.

Test Plan:
1. Reset release, no events, ADDR_W=8 -> pc_o steps 0,1,2,3 with fetch_valid_o=1 after the first post-reset cycle; state_o=0.
2. At pc=0x10, br_taken_i=1 and jmp_i=1 in the same cycle, br_target=0x40, jmp_target=0x80 -> pc_o=0x80, flush_o high for 1 cycle, then 0x80 valid, 0x81 next; redirect_cnt_o=1.
3. stall_i high 3 cycles at pc=0x05 -> pc_o stays 0x05 with fetch_valid_o=0 for 3 cycles, state_o=1, then 0x06.
4. pc=0xFE, free-run -> 0xFF then 0x00 with wrap_o=1 only on the 0x00 cycle; a jump to 0x00 later gives wrap_o=0.
5. halt_i at pc=0x20, then jmp_i while halted, then resume_i -> pc_o holds 0x20 and the jump is ignored; after resume, pc_o goes to 0x21.
6. FLUSH_CYC=2: redirect to 0x30, second redirect to 0x50 during flush, then rst asserted mid-FLUSH -> 0x50 with the counter reloaded; rst gives pc_o=RESET_VEC, flush_o=0, redirect_cnt_o=0.
